pipe_chain_hs: RTL and testbench
================================

// Module: pipe_chain_hs
// PURPOSE
//  Generic N-stage elastic pipeline register chain with valid/ready handshake, per-stage stall
//  and per-stage flush. Replaces the fixed IF_ID/ID_EX/EX_MEM/MEM_WB registers in the CPU.
//  Load-use bubbles come from stalling a stage; branch/jump kills come from flushing stages.
//  Stage contents are exported so the forwarding/hazard logic can inspect them.
// PARAMETERS
//  DATA_W  64  payload width per stage (control + operands + PC, packed by the user)
//  STAGES  4   number of register stages, >=1; stage 0 is youngest, STAGES-1 drives output
// PORTS
//  clk          in   1               main clock
//  srst         in   1               synchronous reset, active-high
//  enable       in   1               global advance qualifier (CPU 'enable')
//  in_valid     in   1               upstream payload valid
//  in_ready     out  1               chain accepts in_data this cycle
//  in_data      in   DATA_W          upstream payload
//  out_valid    out  1               stage STAGES-1 presents valid payload
//  out_ready    in   1               downstream accepts out_data
//  out_data     out  DATA_W          payload of stage STAGES-1
//  stall        in   STAGES          bit k: stage k holds its content, loads nothing
//  flush        in   STAGES          bit k: kill the content of stage k this cycle
//  stage_valid  out  STAGES          registered valid bit per stage (pre-flush)
//  stage_data   out  STAGES*DATA_W   stage k payload at [k*DATA_W +: DATA_W]
//  occupancy    out  $clog2(STAGES+1) popcount of stage_valid
// BEHAVIOUR
//  - State per stage k: v[k], d[k]. srst: v=0, d=0 -> out_valid=0, occupancy=0, stage_data=0.
//  - Combinational chain, evaluated from stage STAGES-1 down to 0:
//      ve[k]    = v[k] & ~flush[k]
//      ld[S]    = out_ready      (S = STAGES)
//      leave[k] = ve[k] & ~stall[k] & ld[k+1]
//      ld[k]    = enable & ~stall[k] & (~ve[k] | leave[k])
//  - in_ready = ld[0]; out_valid = ve[S-1] & ~stall[S-1] & enable; out_data = d[S-1].
//  - in_ready and out_valid never depend on in_valid. out_valid may depend on flush/stall/enable
//    but never on out_ready.
//  - Next state: if ld[k]: v[k] <= inc[k], and d[k] <= src data only when inc[k]=1 (otherwise d held);
//      else v[k] <= ve[k], d held.
//      inc[0] = in_valid, src data = in_data; inc[k>0] = leave[k-1], src data = d[k-1].
//  - Latency: item accepted at edge t appears on out_valid after STAGES edges with no stall.
//    Throughput is 1 item/cycle.
//  - Stalled stage k with downstream moving: stage k+1 loads a bubble (v=0).
//    A stall never duplicates or drops an item.
//  - Flush beats stall; flush of stage k does not affect other stages.
//    A flushed item never reaches the output.
//  - Flush is applied even when enable=0.
//  - enable=0: in_ready=0, out_valid=0, all non-flushed contents held.
//  - Full chain with out_ready=0: in_ready=0, with no loss. Output fire and input accept in the
//    same cycle are legal; occupancy is unchanged.
//  - srst mid-operation discards all items. On the next cycle in_ready=enable & ~stall[0].
//  - Ordering: items leave in acceptance order, always.
// TESTING
//  1. STAGES=4, enable=1, out_ready=1, push 0x1..0x8 back-to-back -> out_data 0x1..0x8 on
//     consecutive cycles, first valid 4 edges after the first accept, occupancy steady at 4.
//  2. Fill the chain, hold out_ready=0 for 5 cycles -> in_ready=0 after 4 accepts,
//     occupancy=4, stage_data stable. Release -> 0x1.. drained in order.
//  3. A in stage1, B in stage0, stall=4'b0010 for 1 cycle -> stage2 gets a bubble,
//     exactly one idle out_valid cycle, then A, B in order.
//  4. Stages 3..0 hold 1,2,3,4, flush=4'b0011 for 1 cycle -> only 1,2 emerge,
//     occupancy drops 4->2 (minus any output fire).
//  5. flush[1] together with stall[1] -> stage1 cleared next cycle.
//     srst with 4 valid -> next cycle occupancy=0, out_valid=0, stage_data=0.
//  6. enable=0 for 3 cycles mid-stream -> in_ready=0, out_valid=0, contents held.
//     enable=1 -> stream resumes without loss or duplication.

Source files
------------

// File: rtl/pipe_chain_hs.sv
// pipe_chain_hs: N-stage elastic register chain with valid/ready handshake,
// per-stage stall and per-stage flush. Stage 0 is the youngest stage and
// stage STAGES-1 drives the output.
// Ports:
//   clk, srst                 clock, synchronous active-high reset
//   enable                    global advance qualifier
//   in_valid/in_ready/in_data upstream handshake and payload
//   out_valid/out_ready/out_data downstream handshake and payload
//   stall, flush              per-stage hold / kill controls
//   stage_valid, stage_data   raw stage contents, before flush is applied
//   occupancy                 number of valid stages
module pipe_chain_hs #(
   parameter  int unsigned DATA_W = 64,
   parameter  int unsigned STAGES = 4,
   localparam int unsigned OCC_W  = $clog2(STAGES + 1)
) (
   input  logic                       clk,
   input  logic                       srst,
   input  logic                       enable,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   input  logic [STAGES-1:0]          stall,
   input  logic [STAGES-1:0]          flush,
   output logic [STAGES-1:0]          stage_valid,
   output logic [STAGES*DATA_W-1:0]   stage_data,
   output logic [OCC_W-1:0]           occupancy
);

   logic [STAGES-1:0] v_q, v_d;
   logic [DATA_W-1:0] d_q [STAGES];
   logic [DATA_W-1:0] d_d [STAGES];

   logic [STAGES-1:0] ve;     // stage valid after flush
   logic [STAGES-1:0] leave;  // stage content moves on this cycle
   logic [STAGES:0]   ld;     // stage may load this cycle; ld[STAGES] is the sink

   // Readiness ripples from the output back toward stage 0.
   always_comb begin : chain_comb
      ve         = '0;
      leave      = '0;
      ld         = '0;
      ld[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         ve[k]    = v_q[k] & ~flush[k];
         leave[k] = ve[k] & ~stall[k] & ld[k+1];
         ld[k]    = enable & ~stall[k] & (~ve[k] | leave[k]);
      end
   end

   // Next-state: a loading stage takes its upstream item or a bubble; a
   // non-loading stage keeps its (possibly flushed) content. Data only moves
   // with a valid item so bubbles leave the old payload in place.
   always_comb begin : next_comb
      v_d = v_q;
      d_d = d_q;
      if (ld[0]) begin
         v_d[0] = in_valid;
         if (in_valid) begin
            d_d[0] = in_data;
         end
      end else begin
         v_d[0] = ve[0];
      end
      for (int k = 1; k < STAGES; k++) begin
         if (ld[k]) begin
            v_d[k] = leave[k-1];
            if (leave[k-1]) begin
               d_d[k] = d_q[k-1];
            end
         end else begin
            v_d[k] = ve[k];
         end
      end
   end

   // Stage registers.
   always_ff @(posedge clk) begin : state_reg
      if (srst) begin
         v_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            d_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   // Exported views of the chain.
   always_comb begin : export_comb
      stage_data = '0;
      occupancy  = '0;
      for (int k = 0; k < STAGES; k++) begin
         stage_data[k*DATA_W +: DATA_W] = d_q[k];
         occupancy = occupancy + OCC_W'(v_q[k]);
      end
   end

   assign stage_valid = v_q;
   assign in_ready    = ld[0];
   assign out_valid   = ve[STAGES-1] & ~stall[STAGES-1] & enable;
   assign out_data    = d_q[STAGES-1];

endmodule

// File: tb/tb_pipe_chain_hs.sv
// tb_pipe_chain_hs: directed scenarios plus a randomized run of pipe_chain_hs,
// compared every cycle against a slot-occupancy reference model, with
// output-order checks against fixed expected sequences.
module tb_pipe_chain_hs;
   localparam int unsigned DW = 64;
   localparam int unsigned S  = 4;

   logic          clk = 1'b0;
   logic          srst, enable, in_valid, out_ready;
   logic [DW-1:0] in_data;
   logic [S-1:0]  stall, flush;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [S-1:0]  stage_valid;
   logic [S*DW-1:0] stage_data;
   logic [2:0]    occupancy;

   always #5 clk = ~clk;

   pipe_chain_hs #(.DATA_W(DW), .STAGES(S)) dut (
      .clk(clk), .srst(srst), .enable(enable),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall(stall), .flush(flush),
      .stage_valid(stage_valid), .stage_data(stage_data), .occupancy(occupancy)
   );

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;

   // Reference model: which slots hold an item and what it is.
   logic          m_v [S];
   logic [DW-1:0] m_d [S];

   logic [DW-1:0] fires[$];
   int            fire_cyc[$];
   int            acc_cyc[$];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      fires.delete();
      fire_cyc.delete();
      acc_cyc.delete();
   endtask

   // One clock: predict, compare mid-cycle, then advance the model at the edge.
   task automatic step();
      logic live [S];
      logic takes [S];
      logic moves [S];
      logic space;
      logic e_ov;
      int   occ;
      @(negedge clk);
      space = out_ready;
      occ   = 0;
      for (int k = S - 1; k >= 0; k--) begin
         live[k] = m_v[k] && !flush[k];
         if (!enable || stall[k]) begin
            takes[k] = 1'b0;
            moves[k] = 1'b0;
         end else begin
            moves[k] = live[k] && space;
            takes[k] = !live[k] || moves[k];
         end
         space = takes[k];
         if (m_v[k]) occ++;
      end
      e_ov = enable && live[S-1] && !stall[S-1];
      chk("in_ready", DW'(in_ready), DW'(takes[0]));
      chk("out_valid", DW'(out_valid), DW'(e_ov));
      chk("out_data", out_data, m_d[S-1]);
      chk("occupancy", DW'(occupancy), DW'(occ));
      for (int k = 0; k < S; k++) begin
         chk($sformatf("stage_valid%0d", k), DW'(stage_valid[k]), DW'(m_v[k]));
         chk($sformatf("stage_data%0d", k), stage_data[k*DW +: DW], m_d[k]);
      end
      if (out_valid && out_ready) begin
         fires.push_back(out_data);
         fire_cyc.push_back(cyc_n);
      end
      if (takes[0] && in_valid) acc_cyc.push_back(cyc_n);
      @(posedge clk);
      cyc_n++;
      if (srst) begin
         for (int k = 0; k < S; k++) begin
            m_v[k] = 1'b0;
            m_d[k] = '0;
         end
      end else begin
         for (int k = S - 1; k >= 1; k--) begin
            if (takes[k]) begin
               m_v[k] = moves[k-1];
               if (moves[k-1]) m_d[k] = m_d[k-1];
            end else begin
               m_v[k] = live[k];
            end
         end
         if (takes[0]) begin
            m_v[0] = in_valid;
            if (in_valid) m_d[0] = in_data;
         end else begin
            m_v[0] = live[0];
         end
      end
      #1;
   endtask

   task automatic check_fires(input string tag, input int n, input logic [DW-1:0] first);
      chk({tag, "_count"}, DW'(fires.size()), DW'(n));
      for (int i = 0; i < n && i < fires.size(); i++)
         chk($sformatf("%s_item%0d", tag, i), fires[i], first + DW'(i));
   endtask

   initial begin
      srst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b1; stall = '0; flush = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < S; k++) begin
         m_v[k] = 1'b0;
         m_d[k] = '0;
      end
      srst = 1'b0;
      chk("reset_occ", DW'(occupancy), 0);
      chk("reset_out_valid", DW'(out_valid), 0);

      // Back-to-back stream 1..8.
      clear_logs();
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = DW'(i);
         step();
         if (i == 4) chk("t1_occ_full", DW'(occupancy), 4);
      end
      in_valid = 1'b0;
      repeat (6) step();
      check_fires("t1", 8, 1);
      if (fire_cyc.size() == 8 && acc_cyc.size() == 8) begin
         chk("t1_latency", DW'(fire_cyc[0] - acc_cyc[0]), 4);
         chk("t1_back2back", DW'(fire_cyc[7] - fire_cyc[0]), 7);
      end else begin
         chk("t1_log_sizes", DW'(fire_cyc.size() + acc_cyc.size()), 16);
      end

      // Backpressure: fill, hold out_ready low, then drain.
      clear_logs();
      out_ready = 1'b0;
      repeat (9) begin
         in_valid = 1'b1; in_data = DW'(acc_cyc.size() + 1);
         step();
      end
      in_valid = 1'b0;
      chk("t2_accepts", DW'(acc_cyc.size()), 4);
      chk("t2_occ", DW'(occupancy), 4);
      chk("t2_in_ready", DW'(in_ready), 0);
      chk("t2_stage3", stage_data[3*DW +: DW], 1);
      chk("t2_stage0", stage_data[0 +: DW], 4);
      out_ready = 1'b1;
      repeat (6) step();
      check_fires("t2", 4, 1);

      // Stall stage 1 holding A while B waits in stage 0.
      clear_logs();
      in_valid = 1'b1; in_data = 64'hA; step();
      in_data = 64'hB; step();
      in_valid = 1'b0; stall = 4'b0010; step();
      stall = '0;
      repeat (6) step();
      check_fires("t3", 2, 64'hA);
      if (fire_cyc.size() == 2 && acc_cyc.size() == 2) begin
         chk("t3_one_bubble", DW'(fire_cyc[0] - acc_cyc[0]), 5);
         chk("t3_gap", DW'(fire_cyc[1] - fire_cyc[0]), 1);
      end else begin
         chk("t3_log_sizes", DW'(fire_cyc.size() + acc_cyc.size()), 4);
      end

      // Flush the two youngest stages of a full chain.
      clear_logs();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_data = DW'(i);
         step();
      end
      in_valid = 1'b0; flush = 4'b0011; step();
      flush = '0;
      chk("t4_occ", DW'(occupancy), 2);
      out_ready = 1'b1;
      repeat (6) step();
      check_fires("t4", 2, 1);

      // Flush wins over stall on the same stage.
      clear_logs();
      in_valid = 1'b1; in_data = 64'h51; step();
      in_data = 64'h52; step();
      in_valid = 1'b0; stall = 4'b0010; flush = 4'b0010; step();
      stall = '0; flush = '0;
      chk("t5_stage1_cleared", DW'(stage_valid[1]), 0);
      chk("t5_stage0_kept", DW'(stage_valid[0]), 1);
      repeat (6) step();
      check_fires("t5a", 1, 64'h52);

      // Reset with a full chain.
      clear_logs();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_data = DW'(i + 32'h70);
         step();
      end
      in_valid = 1'b0; srst = 1'b1; step();
      srst = 1'b0;
      chk("t5_srst_occ", DW'(occupancy), 0);
      chk("t5_srst_out_valid", DW'(out_valid), 0);
      chk("t5_srst_in_ready", DW'(in_ready), 1);
      for (int k = 0; k < S; k++)
         chk($sformatf("t5_srst_data%0d", k), stage_data[k*DW +: DW], 0);
      out_ready = 1'b1;
      repeat (5) step();
      chk("t5_no_fires", DW'(fires.size()), 0);

      // Global enable dropped mid-stream.
      clear_logs();
      for (int i = 0; i < 14; i++) begin
         enable   = !(i >= 4 && i <= 6);
         in_valid = 1'b1; in_data = 64'h61 + DW'(acc_cyc.size());
         step();
      end
      enable = 1'b1; in_valid = 1'b0;
      repeat (8) step();
      chk("t6_accepts", DW'(acc_cyc.size()), 11);
      check_fires("t6", acc_cyc.size(), 64'h61);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         enable    = ($urandom_range(9) != 0);
         in_valid  = $urandom_range(1) != 0;
         in_data   = {$urandom, $urandom};
         out_ready = ($urandom_range(3) != 0);
         stall     = ($urandom_range(4) == 0) ? S'($urandom) : '0;
         flush     = ($urandom_range(7) == 0) ? S'($urandom) : '0;
         srst      = ($urandom_range(99) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
